// File: rtl/ps2_frame_receiver_pkg.sv
// PS/2 frame receiver shared types.
// FSM state encoding and default parameter values.
package ps2_frame_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int DEF_DATA_BITS      = 8;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 5000;
  localparam int DEF_ODD_PARITY     = 1;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Received-word buffer for the PS/2 receiver.
// Registered write, head word shown combinationally, zero when empty.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver.
// Synchronises the lines, deframes on falling edges, buffers good words.
module ps2_frame_receiver
  import ps2_frame_receiver_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ODD_PARITY     = DEF_ODD_PARITY
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 PS2Clk,
  input  logic                 PS2Data,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 Valid,
  input  logic                 Ready,
  output logic                 ParityErr,
  output logic                 FrameErr,
  output logic                 Overflow,
  output logic                 Busy
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [BW-1:0]        bitcnt;
  logic [TW-1:0]        tcnt;
  logic [DATA_BITS-1:0] payload;
  logic                 par_bit;
  logic                 c1, c2, cprev;
  logic                 d1, d2;
  logic                 fall;
  logic                 stop_eval;
  logic                 par_ok;
  logic                 popping;
  logic                 push;
  logic                 full;
  logic                 empty;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      c1    <= 1'b1;
      c2    <= 1'b1;
      cprev <= 1'b1;
      d1    <= 1'b1;
      d2    <= 1'b1;
    end else begin
      c1    <= PS2Clk;
      c2    <= c1;
      cprev <= c2;
      d1    <= PS2Data;
      d2    <= d1;
    end
  end

  assign fall      = cprev && !c2;
  assign stop_eval = fall && (state == STOP);
  assign par_ok    = ((^payload) ^ par_bit) == (ODD_PARITY != 0);
  assign popping   = Valid && Ready;
  assign push      = stop_eval && d2 && par_ok && (!full || popping);
  assign Valid     = !empty;
  assign Busy      = (state != IDLE);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      tcnt      <= '0;
      payload   <= '0;
      par_bit   <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      Overflow  <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (fall && !d2) begin
          state   <= DATA;
          bitcnt  <= '0;
          payload <= '0;
        end
      end else if (fall) begin
        tcnt <= '0;
        case (state)
          DATA: begin
            payload[bitcnt] <= d2;
            if (bitcnt == LAST) state <= PARITY;
            else bitcnt <= bitcnt + 1'b1;
          end
          PARITY: begin
            par_bit <= d2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!d2) FrameErr <= 1'b1;
            else if (!par_ok) ParityErr <= 1'b1;
            else if (full && !popping) Overflow <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (tcnt == TLIM) begin
        // Device stalled mid-frame: abandon the partial word
        state   <= IDLE;
        tcnt    <= '0;
        payload <= '0;
        FrameErr <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  ps2_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (push),
    .pop   (popping),
    .din   (payload),
    .dout  (DataOut),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver.
// Frame-level model plus directed scenarios with literal expectations.
module tb_ps2_frame_receiver;

  localparam int T = 400;
  localparam int H = 20;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic       Ready = 1'b0;
  logic [7:0] DataOut;
  logic       Valid;
  logic       ParityErr;
  logic       FrameErr;
  logic       Overflow;
  logic       Busy;

  ps2_frame_receiver #(
    .DATA_BITS      (8),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (T),
    .ODD_PARITY     (1)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .PS2Clk    (PS2Clk),
    .PS2Data   (PS2Data),
    .DataOut   (DataOut),
    .Valid     (Valid),
    .Ready     (Ready),
    .ParityErr (ParityErr),
    .FrameErr  (FrameErr),
    .Overflow  (Overflow),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame request from the stimulus side
  int         ev_seq = 0;
  int         ev_kind = 0;
  logic [7:0] ev_data = '0;
  logic       ev_par = 1'b0;
  logic       ev_stop = 1'b1;

  // Frame-level model: outcome lands 3 cycles after the final line edge
  logic [7:0] mq[$];
  bit         m_perr, m_ferr, m_ovf;
  int         m_cnt, m_kind, seen_seq;
  logic [7:0] m_data;
  logic       m_par, m_stop;
  bit         m_pop, m_push, m_full;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mq.delete();
      m_perr = 0;
      m_ferr = 0;
      m_ovf = 0;
      m_cnt = 0;
      seen_seq = ev_seq;
    end else begin
      m_perr = 0;
      m_ferr = 0;
      m_ovf = 0;
      m_push = 0;
      m_pop = (mq.size() != 0) && Ready;
      m_full = (mq.size() == DEPTH);
      if (ev_seq != seen_seq) begin
        seen_seq = ev_seq;
        m_kind = ev_kind;
        m_data = ev_data;
        m_par = ev_par;
        m_stop = ev_stop;
        m_cnt = (ev_kind == 2) ? 3 + T : 3;
      end
      if (m_cnt == 1) begin
        m_cnt = 0;
        if (m_kind == 2) m_ferr = 1;
        else if (!m_stop) m_ferr = 1;
        else if (($countones({m_data, m_par}) % 2) == 0) m_perr = 1;
        else if (m_full && !m_pop) m_ovf = 1;
        else m_push = 1;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_data);
    end
  end

  logic [7:0] got[$];
  int perr_seen = 0;
  int ferr_seen = 0;
  int ovf_seen = 0;

  always @(negedge CLK) begin
    chk("Valid", Valid, mq.size() != 0);
    chk("DataOut", DataOut, (mq.size() != 0) ? mq[0] : 8'h00);
    chk("ParityErr", ParityErr, m_perr);
    chk("FrameErr", FrameErr, m_ferr);
    chk("Overflow", Overflow, m_ovf);
    if (Valid && Ready) got.push_back(DataOut);
    if (ParityErr) perr_seen++;
    if (FrameErr) ferr_seen++;
    if (Overflow) ovf_seen++;
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic ps2_bit(logic b, int kind);
    PS2Data = b;
    tick(H);
    PS2Clk = 1'b0;
    if (kind != 0) begin
      ev_kind = kind;
      ev_seq++;
    end
    tick(H);
    PS2Clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, logic par, logic stop);
    ev_data = d;
    ev_par = par;
    ev_stop = stop;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 0);
    ps2_bit(par, 0);
    ps2_bit(stop, 1);
    PS2Data = 1'b1;
    tick(H);
  endtask

  function automatic logic podd(logic [7:0] d);
    return ~^d;
  endfunction

  int gb, pb, fb, ob;

  initial begin
    tick(5);
    chk("rst_valid", Valid, 1'b0);
    chk("rst_dataout", DataOut, 8'h00);
    chk("rst_busy", Busy, 1'b0);
    Reset = 1'b0;
    tick(5);

    // good 0x1C
    Ready = 1'b1;
    gb = got.size(); pb = perr_seen; fb = ferr_seen; ob = ovf_seen;
    send_frame(8'h1C, 1'b0, 1'b1);
    tick(10);
    chk("good_count", got.size() - gb, 1);
    chk("good_word", got[gb], 8'h1C);
    chk("good_noflags", (perr_seen - pb) + (ferr_seen - fb) + (ovf_seen - ob), 0);

    // parity error
    gb = got.size(); pb = perr_seen;
    send_frame(8'h1C, 1'b1, 1'b1);
    tick(10);
    chk("perr_pulses", perr_seen - pb, 1);
    chk("perr_nowrite", got.size() - gb, 0);
    chk("perr_valid", Valid, 1'b0);

    // bad stop bit
    gb = got.size(); fb = ferr_seen;
    send_frame(8'hF0, podd(8'hF0), 1'b0);
    tick(10);
    chk("stop_ferr", ferr_seen - fb, 1);
    chk("stop_nowrite", got.size() - gb, 0);

    // overflow on fifth buffered frame
    Ready = 1'b0;
    ob = ovf_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), podd(8'(i)), 1'b1);
    tick(5);
    chk("ovf_pulses", ovf_seen - ob, 1);
    chk("ovf_valid", Valid, 1'b1);
    chk("ovf_head", DataOut, 8'h01);
    gb = got.size();
    Ready = 1'b1;
    tick(10);
    chk("ovf_popcount", got.size() - gb, 4);
    for (int i = 0; i < 4; i++) chk("ovf_order", got[gb + i], 8'(i + 1));

    // timeout mid-frame
    fb = ferr_seen;
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 2);
    tick(10);
    chk("to_busy_mid", Busy, 1'b1);
    tick(T + 20);
    chk("to_ferr", ferr_seen - fb, 1);
    chk("to_busy_low", Busy, 1'b0);
    gb = got.size();
    send_frame(8'hAA, podd(8'hAA), 1'b1);
    tick(10);
    chk("to_next_count", got.size() - gb, 1);
    chk("to_next_word", got[gb], 8'hAA);

    // reset mid-frame with words buffered
    Ready = 1'b0;
    send_frame(8'h11, podd(8'h11), 1'b1);
    send_frame(8'h22, podd(8'h22), 1'b1);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) ps2_bit(1'(i & 1), 0);
    tick(H);
    chk("pre_rst_busy", Busy, 1'b1);
    chk("pre_rst_valid", Valid, 1'b1);
    pb = perr_seen; fb = ferr_seen; ob = ovf_seen;
    Reset = 1'b1;
    #1;
    chk("rst_mid_valid", Valid, 1'b0);
    chk("rst_mid_busy", Busy, 1'b0);
    chk("rst_mid_dataout", DataOut, 8'h00);
    tick(3);
    Reset = 1'b0;
    tick(5);
    Ready = 1'b1;
    gb = got.size();
    send_frame(8'h55, podd(8'h55), 1'b1);
    tick(10);
    chk("rst_next_count", got.size() - gb, 1);
    chk("rst_next_word", got[gb], 8'h55);
    chk("rst_noflags", (perr_seen - pb) + (ferr_seen - fb) + (ovf_seen - ob), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
